// File: rtl/link_partner.sv
// Far-end partner for the DMG serial link: follows DMG SCK or drives its own SCK,
// shifting one byte out on sin_out while assembling one byte from sout_in.
module link_partner #(
  parameter int HALF_PERIOD = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       master,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  input  logic       start,
  input  logic       sck_in,
  output logic       sck_out,
  output logic       sck_oe,
  output logic       sin_out,
  input  logic       sout_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       tx_empty,
  output logic       overrun
);

  // state | meaning
  // IDLE  | no frame; waiting for DMG SCK fall (follower) or start (master)
  // SHIFT | follower frame in progress, stepping on synced DMG SCK edges
  // LOW   | master frame, SCK driven low, counting down one half period
  // HIGH  | master frame, SCK driven high, counting down one half period
  typedef enum logic [1:0] {IDLE, SHIFT, LOW, HIGH} state_t;

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] HP_M1 = CW'(HALF_PERIOD - 1);

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [3:0]             bit_cnt, bit_n;
  logic [7:0]             tx_sh, tx_n, rx_sh, rx_n, rxd_n, hold, hold_n;
  logic                   rxv_n, busy_n, sck_n, sin_n, empty_n, ovr_n, load;
  logic [SYNC_STAGES-1:0] sck_sync, sout_sync;
  logic                   sck_prev, sck_s, sout_s, rise, fall;

  assign sck_oe = master;
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign sout_s = sout_sync[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev;
  assign fall   = ~sck_s & sck_prev;

  // Sync flops reset to the idle-high level so reset release never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '1;
      sout_sync <= '1;
      sck_prev  <= 1'b1;
    end else begin
      sck_sync[0]  <= sck_in;
      sout_sync[0] <= sout_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i]  <= sck_sync[i-1];
        sout_sync[i] <= sout_sync[i-1];
      end
      sck_prev <= sck_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sh    <= 8'hFF;
      rx_sh    <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      sck_out  <= 1'b1;
      sin_out  <= 1'b1;
      hold     <= 8'h00;
      tx_empty <= 1'b1;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      tx_sh    <= tx_n;
      rx_sh    <= rx_n;
      rx_data  <= rxd_n;
      rx_valid <= rxv_n;
      busy     <= busy_n;
      sck_out  <= sck_n;
      sin_out  <= sin_n;
      hold     <= hold_n;
      tx_empty <= empty_n;
      overrun  <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    tx_n    = tx_sh;
    rx_n    = rx_sh;
    rxd_n   = rx_data;
    rxv_n   = 1'b0;
    busy_n  = busy;
    sck_n   = sck_out;
    sin_n   = sin_out;
    hold_n  = hold;
    empty_n = tx_empty;
    ovr_n   = overrun;
    load    = 1'b0;

    case (state)
      IDLE: begin
        if (!master && fall) begin
          load    = 1'b1;
          busy_n  = 1'b1;
          bit_n   = '0;
          state_n = SHIFT;
        end else if (master && start) begin
          load    = 1'b1;
          busy_n  = 1'b1;
          sck_n   = 1'b0;
          cnt_n   = HP_M1;
          state_n = LOW;
        end
      end
      SHIFT: begin
        if (master) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          bit_n   = '0;
          sck_n   = 1'b1;
        end else if (rise) begin
          rx_n = {rx_sh[6:0], sout_s};
          if (bit_cnt == 4'd7) begin
            rxd_n   = rx_n;
            rxv_n   = 1'b1;
            busy_n  = 1'b0;
            bit_n   = '0;
            state_n = IDLE;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end else if (fall) begin
          tx_n  = {tx_sh[6:0], 1'b1};
          sin_n = tx_n[7];
        end
      end
      LOW: begin
        if (!master) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          bit_n   = '0;
          sck_n   = 1'b1;
        end else if (cnt == '0) begin
          sck_n = 1'b1;
          rx_n  = {rx_sh[6:0], sout_s};
          bit_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            rxd_n = rx_n;
            rxv_n = 1'b1;
          end
          cnt_n   = HP_M1;
          state_n = HIGH;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HIGH: begin
        if (!master) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          bit_n   = '0;
          sck_n   = 1'b1;
        end else if (cnt == '0) begin
          if (bit_cnt == 4'd8) begin
            busy_n  = 1'b0;
            bit_n   = '0;
            state_n = IDLE;
          end else begin
            sck_n   = 1'b0;
            tx_n    = {tx_sh[6:0], 1'b1};
            sin_n   = tx_n[7];
            cnt_n   = HP_M1;
            state_n = LOW;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A same-cycle tx_wr refills the holding register after the load took the old byte.
    if (load) begin
      tx_n    = tx_empty ? 8'hFF : hold;
      sin_n   = tx_n[7];
      empty_n = 1'b1;
    end
    if (tx_wr) begin
      hold_n  = tx_data;
      empty_n = 1'b0;
      if (!tx_empty) ovr_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_link_partner.sv
// Directed bench for link_partner: follower frames, master loopback frames,
// overrun, reset mid-frame and master abort.
module tb_link_partner;

  logic       clk = 1'b0;
  logic       reset, master, tx_wr, start, sck_in, sout_drv, loop_en;
  logic [7:0] tx_data;
  wire        sout_in;
  logic       sck_out, sck_oe, sin_out, rx_valid, busy, tx_empty, overrun;
  logic [7:0] rx_data;

  int checks = 0;
  int failures = 0;

  assign sout_in = loop_en ? sin_out : sout_drv;

  always #5 clk = ~clk;

  link_partner #(.HALF_PERIOD(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .master(master), .tx_data(tx_data), .tx_wr(tx_wr),
    .start(start), .sck_in(sck_in), .sck_out(sck_out), .sck_oe(sck_oe),
    .sin_out(sin_out), .sout_in(sout_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .tx_empty(tx_empty), .overrun(overrun)
  );

  // Drives nbits DMG-side SCK pulses (20 low / 20 high), sout bits MSB first at falls.
  task automatic follower_bits(input logic [7:0] sb, input int nbits,
                               output logic [7:0] sin_bits, output int nv);
    sin_bits = 8'h00;
    nv = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sck_in = 1'b0;
      sout_drv = sb[7-i];
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (rx_valid) nv++;
      end
      sin_bits = {sin_bits[6:0], sin_out};
      sck_in = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (rx_valid) nv++;
      end
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_wr = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  // One master frame with loopback; a start pulse mid-frame must be ignored.
  task automatic do_master(input logic wr, input logic [7:0] d, output int bcyc,
                           output int vat, output int nfall, output int nvld);
    logic prev;
    @(negedge clk);
    tx_wr = wr;
    tx_data = d;
    start = 1'b1;
    bcyc = 0; vat = -1; nfall = 0; nvld = 0; prev = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      tx_wr = 1'b0;
      start = (n == 10);
      if (busy) bcyc++;
      if (rx_valid) begin nvld++; vat = n; end
      if (prev && !sck_out) nfall++;
      prev = sck_out;
    end
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (sck_out !== 1'b1 || sck_oe !== master || sin_out !== 1'b1 || rx_data !== 8'h00 ||
        rx_valid !== 1'b0 || busy !== 1'b0 || tx_empty !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL %s: got sck=%b oe=%b sin=%b rx=%h v=%b busy=%b empty=%b ovr=%b, want 1 %b 1 00 0 0 1 0",
               tag, sck_out, sck_oe, sin_out, rx_data, rx_valid, busy, tx_empty, overrun, master);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset_state");
  endtask

  task automatic test_follower;
    logic [7:0] sb;
    int nv;
    write_tx(8'h3C);
    follower_bits(8'hA5, 8, sb, nv);
    checks++;
    if (rx_data !== 8'hA5) begin failures++; $display("FAIL follower_rx: got %h want a5", rx_data); end
    checks++;
    if (nv !== 1) begin failures++; $display("FAIL follower_valid_count: got %0d want 1", nv); end
    checks++;
    if (sb !== 8'h3C) begin failures++; $display("FAIL follower_sin: got %h want 3c", sb); end
    checks++;
    if (tx_empty !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL follower_end: got empty=%b busy=%b want 1 0", tx_empty, busy);
    end
  endtask

  task automatic test_follower_default;
    logic [7:0] sb;
    int nv;
    follower_bits(8'hC3, 8, sb, nv);
    checks++;
    if (sb !== 8'hFF || rx_data !== 8'hC3 || nv !== 1) begin
      failures++; $display("FAIL follower_default: got sin=%h rx=%h nv=%0d want ff c3 1", sb, rx_data, nv);
    end
    // Lower SCK while in master mode, return to follower, then raise: rise without a fall.
    @(negedge clk); master = 1'b1;
    @(negedge clk); sck_in = 1'b0;
    repeat (6) @(negedge clk);
    master = 1'b0;
    repeat (6) @(negedge clk);
    sck_in = 1'b1;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy || rx_valid) nv++;
    end
    checks++;
    if (nv !== 0 || rx_data !== 8'hC3) begin
      failures++; $display("FAIL spurious_rise: got active=%0d rx=%h want 0 c3", nv, rx_data);
    end
  endtask

  task automatic test_master;
    int bc, va, nf, nvl;
    master = 1'b1;
    loop_en = 1'b1;
    write_tx(8'h81);
    do_master(1'b0, 8'h00, bc, va, nf, nvl);
    checks++;
    if (rx_data !== 8'h81) begin failures++; $display("FAIL master_rx: got %h want 81", rx_data); end
    checks++;
    if (va !== 60 || nvl !== 1) begin failures++; $display("FAIL master_valid: got at=%0d n=%0d want 60 1", va, nvl); end
    checks++;
    if (bc !== 64) begin failures++; $display("FAIL master_busy_len: got %0d want 64", bc); end
    checks++;
    if (nf !== 8) begin failures++; $display("FAIL master_sck_falls: got %0d want 8", nf); end
    checks++;
    if (sck_oe !== 1'b1 || tx_empty !== 1'b1) begin
      failures++; $display("FAIL master_end: got oe=%b empty=%b want 1 1", sck_oe, tx_empty);
    end
  endtask

  task automatic test_overrun;
    int bc, va, nf, nvl;
    @(negedge clk); tx_wr = 1'b1; tx_data = 8'h11;
    @(negedge clk); tx_data = 8'h22;
    @(negedge clk); tx_wr = 1'b0;
    checks++;
    if (overrun !== 1'b1 || tx_empty !== 1'b0) begin
      failures++; $display("FAIL overrun_set: got ovr=%b empty=%b want 1 0", overrun, tx_empty);
    end
    do_master(1'b0, 8'h00, bc, va, nf, nvl);
    checks++;
    if (rx_data !== 8'h22) begin failures++; $display("FAIL overrun_frame: got %h want 22", rx_data); end
    do_master(1'b1, 8'h77, bc, va, nf, nvl);
    checks++;
    if (rx_data !== 8'hFF || tx_empty !== 1'b0 || overrun !== 1'b1) begin
      failures++; $display("FAIL load_collision: got rx=%h empty=%b ovr=%b want ff 0 1", rx_data, tx_empty, overrun);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] sb;
    int nv;
    master = 1'b0;
    loop_en = 1'b0;
    repeat (4) @(negedge clk);
    follower_bits(8'hF0, 4, sb, nv);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_frame_busy: got %b want 1", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid_frame");
    follower_bits(8'h5A, 8, sb, nv);
    checks++;
    if (rx_data !== 8'h5A || nv !== 1 || sb !== 8'hFF) begin
      failures++; $display("FAIL after_reset_frame: got rx=%h nv=%0d sin=%h want 5a 1 ff", rx_data, nv, sb);
    end
  endtask

  task automatic test_abort;
    int nv;
    logic was_busy;
    sout_drv = 1'b0;
    master = 1'b1;
    write_tx(8'h99);
    @(negedge clk); start = 1'b1;
    nv = 0; was_busy = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 5) was_busy = busy;
      if (n == 22) master = 1'b0;
      if (rx_valid) nv++;
    end
    checks++;
    if (was_busy !== 1'b1) begin failures++; $display("FAIL abort_started: got busy=%b want 1", was_busy); end
    checks++;
    if (busy !== 1'b0 || sck_out !== 1'b1 || sck_oe !== 1'b0) begin
      failures++; $display("FAIL abort_state: got busy=%b sck=%b oe=%b want 0 1 0", busy, sck_out, sck_oe);
    end
    checks++;
    if (nv !== 0 || rx_data !== 8'h5A) begin
      failures++; $display("FAIL abort_rx: got nv=%0d rx=%h want 0 5a", nv, rx_data);
    end
  endtask

  initial begin
    reset = 1'b1; master = 1'b0; tx_wr = 1'b0; start = 1'b0; tx_data = 8'h00;
    sck_in = 1'b1; sout_drv = 1'b1; loop_en = 1'b0;
    test_reset();
    test_follower();
    test_follower_default();
    test_master();
    test_overrun();
    test_reset_mid();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
